// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: ALU opcodes, mul/div opcodes and mul/div sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_pkg;

  // Single-cycle ALU operation select.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  // Mul/div unit operation select; encodings 6 and 7 are no-ops.
  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// CPU <-> mul/div request/status bundle; master = CPU control, slave = mul/div unit.
// Latency: n/a (wiring only).
// Backpressure: CPU holds start/op/op_a/op_b while busy is high.
interface mips_cpu_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the shared 2W accumulator.
// Latency: combinational.
// Backpressure: none; the sequencer decides when the result is registered.
// Ports: is_div selects divide; acc is {upper,lower} working register; m is multiplicand
// (multiply) or divisor (divide); acc_next is the accumulator after one step.
module mips_cpu_muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   m,
  output logic [2*DATA_WIDTH-1:0] acc_next
);
  localparam int W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] rs;
  logic [W:0] diff;

  always_comb begin
    sum      = '0;
    rs       = '0;
    diff     = '0;
    acc_next = acc;
    if (!is_div) begin
      // Multiply: acc = {partial product, remaining multiplier bits}. Add the
      // multiplicand into the upper half when the multiplier LSB is set, then
      // shift the whole thing right so the carry lands in the top bit.
      sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : {(W+1){1'b0}});
      acc_next = {sum, acc[W-1:1]};
    end else begin
      // Divide: acc = {partial remainder, dividend/quotient}. Shift the next
      // dividend bit into the remainder and keep the subtraction only if it
      // does not go negative; the quotient bit enters at the bottom.
      rs   = {acc[2*W-1:W], acc[W-1]};
      diff = rs - {1'b0, m};
      if (!diff[W]) begin
        acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_next = {rs[W-1:0], acc[W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write directly.
// Latency: 33 cycles start->done for mul/div, 1 cycle for divide by zero, MTHI/MTLO next edge.
// Backpressure: busy high while computing; any start seen while busy is ignored.
// Ports: clk, reset (sync, active low), bus (slave side: start/op/op_a/op_b in,
// busy/done/hi/lo out).
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  mips_cpu_muldiv_if.slave   bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  muldiv_state_t     state;
  logic [CNT_W-1:0]  counter;
  logic [2*W-1:0]    acc;
  logic [2*W-1:0]    acc_next;
  logic [W-1:0]      mreg;
  logic [W-1:0]      raw_a;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;

  muldiv_op_t        op_in;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic [W-1:0]      a_mag;
  logic [W-1:0]      b_mag;
  logic              b_zero;

  logic [W-1:0]      fix_hi;
  logic [W-1:0]      fix_lo;
  logic [2*W-1:0]    prod_neg;

  assign bus.busy = (state != IDLE);

  // Operand conditioning at the start edge: signed ops work on magnitudes
  // and remember the signs for the final correction.
  always_comb begin
    op_in     = muldiv_op_t'(bus.op);
    signed_op = (op_in == MULT) || (op_in == DIV);
    a_neg     = signed_op & bus.op_a[W-1];
    b_neg     = signed_op & bus.op_b[W-1];
    a_mag     = a_neg ? (~bus.op_a + W'(1)) : bus.op_a;
    b_mag     = b_neg ? (~bus.op_b + W'(1)) : bus.op_b;
    b_zero    = (bus.op_b == '0);
  end

  mips_cpu_muldiv_step #(
    .DATA_WIDTH (W)
  ) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .m        (mreg),
    .acc_next (acc_next)
  );

  // Result formatting for the FIX edge.
  always_comb begin
    prod_neg = ~acc + (2*W)'(1);
    fix_hi   = '0;
    fix_lo   = '0;
    if (div_zero) begin
      // Divide by zero: fixed quotient, raw dividend as remainder, no sign fixup.
      fix_lo = '1;
      fix_hi = raw_a;
    end else if (is_div) begin
      fix_lo = neg_q ? (~acc[W-1:0] + W'(1))   : acc[W-1:0];
      fix_hi = neg_r ? (~acc[2*W-1:W] + W'(1)) : acc[2*W-1:W];
    end else begin
      {fix_hi, fix_lo} = neg_q ? prod_neg : acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= '0;
      acc      <= '0;
      mreg     <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (op_in)
              MTHI: bus.hi <= bus.op_a;
              MTLO: bus.lo <= bus.op_a;
              MULT, MULTU: begin
                is_div   <= 1'b0;
                div_zero <= 1'b0;
                mreg     <= a_mag;
                acc      <= {{W{1'b0}}, b_mag};
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= 1'b0;
                counter  <= '0;
                state    <= CALC;
              end
              DIV, DIVU: begin
                is_div   <= 1'b1;
                div_zero <= b_zero;
                mreg     <= b_mag;
                acc      <= {{W{1'b0}}, a_mag};
                raw_a    <= bus.op_a;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                counter  <= '0;
                // Nothing to iterate on a zero divisor; finish on the next edge.
                state    <= b_zero ? FIX : CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc     <= acc_next;
          counter <= counter + CNT_W'(1);
          if (counter == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          bus.hi   <= fix_hi;
          bus.lo   <= fix_lo;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
Multi-cycle multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs iterative shift-add multiply and restoring divide alongside the single-cycle ALU.
- Exposes a start/busy/done handshake so the CPU control FSM can stall while an operation is in progress.
- HI and LO drive MFHI/MFLO directly.

Parameters:
DATA_WIDTH, 32, operand width; HI/LO are each DATA_WIDTH bits; iteration count = DATA_WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
start  input  1  request; sampled only when busy=0
op  input  3  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6-7 = no-op
op_a  input  32  rs value: multiplicand / dividend / MTHI-MTLO data
op_b  input  32  rt value: multiplier / divisor
busy  output  1  high while in CALC or FIX
done  output  1  one-cycle pulse in the cycle after HI/LO are written by MULT/DIV ops
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. Applies in any state; an in-flight operation is discarded and no done is issued.
- States: IDLE, CALC, FIX. busy = (state != IDLE), decoded combinationally from state.
- IDLE, start=1, op=MTHI or MTLO: hi (or lo) <= op_a at that edge. Stays IDLE; no busy, no done.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operand magnitudes. Signed ops use |x|; unsigned ops use the raw value.
  - Latch the result-sign flags; counter <= 0; state <= CALC.
- IDLE, start=1, op=6 or 7: ignored.
- CALC: one iteration per edge; counter increments; after the iteration with counter=31, state <= FIX. Iterations therefore occupy edges E1..E32.
  - Multiply: 64-bit accumulator, shift-add, LSB-first on the multiplier.
  - Divide: restoring shift-subtract, producing 1 quotient bit per cycle.
- FIX (edge E33):
  - Apply sign correction and write hi/lo; state <= IDLE; done=1 for the following cycle only.
  - Total latency: hi/lo valid and done high 33 cycles after the start edge.
- Multiply result: {hi,lo} = 64-bit product. For MULT, negate the 64-bit magnitude product if the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is a natural wrap; no trap is raised.
- Divide by zero (op_b=0, DIV or DIVU): detected at E0 and goes directly to FIX.
  - FIX writes lo=0xFFFFFFFF, hi=op_a (raw value), and done pulses after E1.
  - Signed correction is not applied.
- start while busy=1: ignored for every op, including MTHI/MTLO. The CPU stalls and must hold the request.
- done and a new start in the same cycle: the start is accepted, since state is IDLE by then.
- hi/lo change only at a FIX edge, an MTHI/MTLO edge or reset. During CALC they keep their old values, so MFHI issued during busy returns the previous value. The CPU control FSM stalls MFHI/MFLO while busy.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - muldiv_op_t enum (3 bits, values as above);
  - muldiv_state_t enum (IDLE, CALC, FIX);
  - constant MULDIV_ITERS = 32.
- The ALU opcode enum moves to the same package.
- No sub-module required. Optionally, split the per-iteration datapath into mips_cpu_muldiv_step (combinational, one multiply or divide step), leaving sequencing in this block.

Test Plan:
- MULTU op_a=0xFFFFFFFF op_b=0xFFFFFFFF -> busy high 33 cycles; done one cycle; hi=0xFFFFFFFE lo=0x00000001.
- MULT op_a=0xFFFFFFFD (-3) op_b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIV op_a=0xFFFFFFF9 (-7) op_b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU op_a=7 op_b=0 -> done after 2nd edge; lo=0xFFFFFFFF hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- MTHI 0x12345678 while idle -> hi updates next edge, busy/done stay 0. MTLO 0xDEAD issued at cycle 5 of a MULTU -> ignored; lo reflects only the product.
- Second start held during busy (DIVU 100/7) -> accepted in the done cycle; lo=14 hi=2 after a further 33 cycles.
- reset=0 at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse; a subsequent MULTU 3*4 gives lo=12 hi=0.
